// File: rtl/sprite_pattern_gen.sv
// sprite_pattern_gen
//   Background pattern plus up to NUM_SPRITES solid-colour rectangles per pixel,
//   producing registered 24-bit RGB with a fixed 2-cycle latency.
//
//   Sprite registers are double-buffered. The host writes a shadow set through
//   the wr_* port. The shadow set is copied to the live set at the last active
//   pixel of each frame, together with bg_mode. This keeps a sprite from tearing
//   mid-frame.
//
//   Optional macro: SPRITE_COLLIDE_EN. When it is defined, collision reports
//   whether two or more sprites overlapped on a visible pixel in the previous
//   frame. When it is undefined, collision is tied to 0.
//
// Ports
//   clock, reset              pixel clock; synchronous active-high reset
//   pixel_valid, x, y         current pixel (stage-0 input)
//   wr_en, wr_idx             shadow write strobe and sprite index
//                             (an index >= NUM_SPRITES is dropped)
//   wr_en_sprite, wr_x,
//   wr_y, wr_color            shadow entry contents written
//   bg_mode                   0 checker, 1 black, 2 h-gradient, 3 scrolling checker
//   r, g, b                   output colour (0 when out_valid=0)
//   out_valid                 pixel_valid delayed 2 cycles
//   sprite_hit                some live sprite covers the output pixel
//   frame_count               frames latched since reset, wraps at 256
//   collision                 previous-frame sprite overlap flag

module sprite_hit_unit #(
    parameter int COORD_W  = 13,
    parameter int SPRITE_W = 256,
    parameter int SPRITE_H = 64
) (
    input  logic               en,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    output logic               hit
);
    // The compare is one bit wider than the coordinates, so sx+SPRITE_W cannot
    // wrap back to small x values.
    localparam logic [COORD_W:0] SW = (COORD_W+1)'(SPRITE_W);
    localparam logic [COORD_W:0] SH = (COORD_W+1)'(SPRITE_H);

    logic [COORD_W:0] pxE, pyE, sxE, syE;

    always_comb begin
        pxE = {1'b0, px};
        pyE = {1'b0, py};
        sxE = {1'b0, sx};
        syE = {1'b0, sy};
        hit = en && (pxE >= sxE) && (pxE < sxE + SW)
                 && (pyE >= syE) && (pyE < syE + SH);
    end
endmodule

module sprite_pattern_gen #(
    parameter int COORD_W     = 13,
    parameter int H_ACTIVE    = 1024,
    parameter int V_ACTIVE    = 768,
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_W    = 256,
    parameter int SPRITE_H    = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               wr_en,
    input  logic [2:0]         wr_idx,
    input  logic               wr_en_sprite,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [23:0]        wr_color,
    input  logic [1:0]         bg_mode,
    output logic [7:0]         r,
    output logic [7:0]         g,
    output logic [7:0]         b,
    output logic               out_valid,
    output logic               sprite_hit,
    output logic [7:0]         frame_count,
    output logic               collision
);
    localparam int STAGES = 2;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [23:0]        color;
    } spriteT;

    spriteT [NUM_SPRITES-1:0] shadow;
    spriteT [NUM_SPRITES-1:0] live;
    logic   [1:0]             bgLive;

    // Stage 0 is the raw input. Stages 1..STAGES are registered.
    logic [STAGES:1] vldReg;
    wire  [STAGES:0] vldPipe = {vldReg, pixel_valid};

    logic [COORD_W-1:0] xS1, yS1;

    wire latchEvt = pixel_valid
                 && (x == COORD_W'(H_ACTIVE - 1))
                 && (y == COORD_W'(V_ACTIVE - 1));

    // ---------------- shadow / live sprite registers ----------------
    // Both updates are non-blocking. On a latch edge that also carries a write,
    // live therefore receives the pre-write shadow entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            shadow      <= '0;
            live        <= '0;
            bgLive      <= 2'd0;
            frame_count <= 8'd0;
        end else begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (wr_en && wr_idx == 3'(i)) begin
                    shadow[i].en    <= wr_en_sprite;
                    shadow[i].sx    <= wr_x;
                    shadow[i].sy    <= wr_y;
                    shadow[i].color <= wr_color;
                end
            end
            if (latchEvt) begin
                live        <= shadow;
                bgLive      <= bg_mode;
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    // ---------------- stage 1: register pixel ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            vldReg[1] <= 1'b0;
            xS1       <= '0;
            yS1       <= '0;
        end else begin
            vldReg[1] <= vldPipe[0];
            xS1       <= x;
            yS1       <= y;
        end
    end

    // ---------------- per-sprite hit test ----------------
    logic [NUM_SPRITES-1:0] hits;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : gHit
        sprite_hit_unit #(
            .COORD_W (COORD_W),
            .SPRITE_W(SPRITE_W),
            .SPRITE_H(SPRITE_H)
        ) uHit (
            .en (live[i].en),
            .sx (live[i].sx),
            .sy (live[i].sy),
            .px (xS1),
            .py (yS1),
            .hit(hits[i])
        );
    end

    // The loop runs from the highest index down, so the lowest-indexed hitting
    // sprite is the one that lands last and supplies the colour.
    logic [23:0] sprColor;
    logic        hitAny;

    always_comb begin
        sprColor = 24'h0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hits[i]) sprColor = live[i].color;
        end
        hitAny = |hits;
    end

    // ---------------- background ----------------
    logic [7:0] x8, y8, bgR, bgG, bgB;

    always_comb begin
        x8  = xS1[7:0];
        y8  = yS1[7:0];
        bgR = 8'h0;
        bgG = 8'h0;
        bgB = 8'h0;
        case (bgLive)
            2'd0: begin
                bgR = x8 ^ y8;
                bgB = x8 ^ y8;
            end
            2'd1: ;
            2'd2: begin
                bgR = x8;
                bgG = x8;
                bgB = x8;
            end
            default: begin
                bgR = (x8 + frame_count) ^ y8;
                bgB = (x8 + frame_count) ^ y8;
            end
        endcase
    end

    // ---------------- stage 2: register colour ----------------
    always_ff @(posedge clock) begin
        if (reset) begin
            vldReg[2]  <= 1'b0;
            r          <= 8'h0;
            g          <= 8'h0;
            b          <= 8'h0;
            sprite_hit <= 1'b0;
        end else begin
            vldReg[2] <= vldPipe[1];
            if (!vldPipe[1]) begin
                r          <= 8'h0;
                g          <= 8'h0;
                b          <= 8'h0;
                sprite_hit <= 1'b0;
            end else if (hitAny) begin
                {r, g, b}  <= sprColor;
                sprite_hit <= 1'b1;
            end else begin
                r          <= bgR;
                g          <= bgG;
                b          <= bgB;
                sprite_hit <= 1'b0;
            end
        end
    end

    assign out_valid = vldReg[STAGES];

`ifdef SPRITE_COLLIDE_EN
    // Two or more bits set: clearing the lowest set bit leaves something.
    wire collNow = vldPipe[1] && ((hits & (hits - NUM_SPRITES'(1))) != '0);
    logic collFlag;

    always_ff @(posedge clock) begin
        if (reset) begin
            collFlag  <= 1'b0;
            collision <= 1'b0;
        end else if (latchEvt) begin
            collision <= collFlag;
            collFlag  <= collNow;
        end else begin
            collFlag  <= collFlag | collNow;
        end
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_pattern_gen.sv
module tb_sprite_pattern_gen;
    localparam int COORD_W = 13;

`ifdef SPRITE_COLLIDE_EN
    localparam logic COLL = 1'b1;
`else
    localparam logic COLL = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset;
    logic               pixel_valid;
    logic [COORD_W-1:0] x, y;
    logic               wr_en;
    logic [2:0]         wr_idx;
    logic               wr_en_sprite;
    logic [COORD_W-1:0] wr_x, wr_y;
    logic [23:0]        wr_color;
    logic [1:0]         bg_mode;
    logic [7:0]         r, g, b;
    logic               out_valid, sprite_hit;
    logic [7:0]         frame_count;
    logic               collision;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    sprite_pattern_gen dut (
        .clock(clock), .reset(reset), .pixel_valid(pixel_valid), .x(x), .y(y),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_en_sprite(wr_en_sprite),
        .wr_x(wr_x), .wr_y(wr_y), .wr_color(wr_color), .bg_mode(bg_mode),
        .r(r), .g(g), .b(b), .out_valid(out_valid), .sprite_hit(sprite_hit),
        .frame_count(frame_count), .collision(collision)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one pixel, then confirm it emerges exactly two edges later.
    task automatic pixCheck(input string tag, input int px, input int py,
                            input logic [23:0] rgb, input logic hit);
        pixel_valid = 1'b1;
        x = COORD_W'(px);
        y = COORD_W'(py);
        tick();
        pixel_valid = 1'b0;
        chk({tag, "_lat1_ov"}, 32'(out_valid), 32'd0);
        tick();
        chk({tag, "_ov"},  32'(out_valid), 32'd1);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'(rgb));
        chk({tag, "_hit"}, 32'(sprite_hit), 32'(hit));
    endtask

    task automatic writeSprite(input int idx, input logic en, input int sx, input int sy,
                               input logic [23:0] col);
        wr_en = 1'b1;
        wr_idx = 3'(idx);
        wr_en_sprite = en;
        wr_x = COORD_W'(sx);
        wr_y = COORD_W'(sy);
        wr_color = col;
        tick();
        wr_en = 1'b0;
    endtask

    // Last active pixel of the frame; any pending wr_* rides the same edge.
    task automatic latchFrame();
        pixel_valid = 1'b1;
        x = COORD_W'(1023);
        y = COORD_W'(767);
        tick();
        wr_en = 1'b0;
        pixel_valid = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        pixel_valid = 1'b0;
        x = '0;
        y = '0;
        wr_en = 1'b0;
        wr_idx = 3'd0;
        wr_en_sprite = 1'b0;
        wr_x = '0;
        wr_y = '0;
        wr_color = 24'h0;
        bg_mode = 2'd0;
        tick();
        tick();
        chk("rst_rgb", 32'({r, g, b}), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_hit", 32'(sprite_hit), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        reset = 1'b0;
        tick();

        // Checker background, 2-cycle latency, valid drops afterwards.
        pixCheck("bg53", 5, 3, 24'h060006, 1'b0);
        tick();
        chk("bg53_idle_ov", 32'(out_valid), 32'd0);
        chk("bg53_idle_rgb", 32'({r, g, b}), 32'd0);

        // The shadow write is not visible before a latch.
        writeSprite(0, 1'b1, 100, 50, 24'hFF0000);
        pixCheck("prelatch", 120, 60, 24'h440044, 1'b0);

        latchFrame();
        chk("fc1", 32'(frame_count), 32'd1);
        pixCheck("s0_in", 120, 60, 24'hFF0000, 1'b1);
        pixCheck("s0_right", 356, 60, 24'h580058, 1'b0);
        pixCheck("s0_left", 99, 60, 24'h5F005F, 1'b0);
        pixCheck("s0_below", 120, 114, 24'h0A000A, 1'b0);

        // Overlap: the lowest index wins.
        writeSprite(0, 1'b1, 100, 50, 24'h00FF00);
        writeSprite(1, 1'b1, 200, 50, 24'h0000FF);
        latchFrame();
        chk("fc2", 32'(frame_count), 32'd2);
        pixCheck("prio", 250, 60, 24'h00FF00, 1'b1);
        pixCheck("s1_only", 400, 60, 24'h0000FF, 1'b1);

        writeSprite(1, 1'b0, 200, 50, 24'h0000FF);
        latchFrame();
        chk("coll_set", 32'(collision), 32'(COLL));
        pixCheck("s1_off", 250, 60, 24'h00FF00, 1'b1);
        pixCheck("s1_gone", 400, 60, 24'hAC00AC, 1'b0);

        // Right-edge sprite, no wrap to low x.
        writeSprite(0, 1'b1, 1014, 0, 24'h123456);
        latchFrame();
        chk("coll_clear", 32'(collision), 32'd0);
        pixCheck("edge_l", 1014, 10, 24'h123456, 1'b1);
        pixCheck("edge_r", 1023, 10, 24'h123456, 1'b1);
        pixCheck("edge_out", 1013, 10, 24'hFF00FF, 1'b0);
        pixCheck("nowrap0", 0, 10, 24'h0A000A, 1'b0);
        pixCheck("nowrap245", 245, 10, 24'hFF00FF, 1'b0);

        // Write on the latch cycle becomes live one frame later.
        wr_en = 1'b1;
        wr_idx = 3'd0;
        wr_en_sprite = 1'b1;
        wr_x = COORD_W'(300);
        wr_y = COORD_W'(0);
        wr_color = 24'hABCDEF;
        latchFrame();
        pixCheck("wrlatch_old", 1014, 10, 24'h123456, 1'b1);
        pixCheck("wrlatch_new0", 310, 10, 24'h3C003C, 1'b0);
        latchFrame();
        pixCheck("wrlatch_new1", 310, 10, 24'hABCDEF, 1'b1);

        // Out-of-range index is dropped.
        writeSprite(4, 1'b1, 0, 0, 24'hFFFFFF);
        latchFrame();
        pixCheck("idx4_drop", 5, 5, 24'h000000, 1'b0);

        bg_mode = 2'd2;
        latchFrame();
        pixCheck("grad", 55, 9, 24'h373737, 1'b0);
        bg_mode = 2'd1;
        latchFrame();
        pixCheck("black", 55, 9, 24'h000000, 1'b0);

        // Scrolling checker follows frame_count.
        bg_mode = 2'd3;
        latchFrame();
        chk("fc10", 32'(frame_count), 32'd10);
        pixCheck("scroll10", 0, 0, 24'h0A000A, 1'b0);
        pixCheck("scroll10b", 3, 5, 24'h080008, 1'b0);
        latchFrame();
        chk("fc11", 32'(frame_count), 32'd11);
        pixCheck("scroll11", 0, 0, 24'h0B000B, 1'b0);
        for (int i = 0; i < 244; i++) latchFrame();
        chk("fc255", 32'(frame_count), 32'd255);
        pixCheck("scroll255", 0, 0, 24'hFF00FF, 1'b0);
        latchFrame();
        chk("fc_wrap", 32'(frame_count), 32'd0);
        pixCheck("scroll0", 0, 0, 24'h000000, 1'b0);
        pixCheck("scroll0b", 3, 5, 24'h060006, 1'b0);

        // Reset mid-frame flushes the pipe and disables live sprites.
        pixel_valid = 1'b1;
        x = COORD_W'(310);
        y = COORD_W'(10);
        tick();
        reset = 1'b1;
        tick();
        chk("mrst_ov", 32'(out_valid), 32'd0);
        chk("mrst_rgb", 32'({r, g, b}), 32'd0);
        chk("mrst_hit", 32'(sprite_hit), 32'd0);
        chk("mrst_fc", 32'(frame_count), 32'd0);
        reset = 1'b0;
        pixel_valid = 1'b0;
        tick();
        pixCheck("mrst_live", 310, 10, 24'h3C003C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_pattern_gen.md
Name: sprite_pattern_gen

Overview:
Parametrised successor to the single-sprite checker pattern block. It generates background plus up to NUM_SPRITES solid-colour rectangular sprites per pixel, and drives 24-bit RGB into the video output path. Sprite registers are double-buffered: a host-side shadow set is copied to the live set once per frame at the last active pixel, so no sprite tears mid-frame. Output is registered with a fixed 2-cycle latency.

Parameters:
COORD_W, 13, width of x/y pixel coordinates
H_ACTIVE, 1024, active pixels per line
V_ACTIVE, 768, active lines per frame
NUM_SPRITES, 4, number of sprites (1..8)
SPRITE_W, 256, sprite width in pixels
SPRITE_H, 64, sprite height in lines

Ports:
clock  in  1  pixel clock, all logic on rising edge
reset  in  1  synchronous, active-high
pixel_valid  in  1  x/y is an active pixel this cycle
x  in  COORD_W  current pixel column
y  in  COORD_W  current pixel row
wr_en  in  1  shadow register write strobe
wr_idx  in  3  sprite index to write (ignored if >= NUM_SPRITES)
wr_en_sprite  in  1  sprite enable bit written
wr_x  in  COORD_W  sprite left edge written
wr_y  in  COORD_W  sprite top edge written
wr_color  in  24  sprite RGB {r,g,b} written
bg_mode  in  2  background: 0 checker, 1 solid black, 2 horizontal gradient, 3 scrolling checker
r  out  8  red
g  out  8  green
b  out  8  blue
out_valid  out  1  pixel_valid delayed 2 cycles
sprite_hit  out  1  a sprite covers the output pixel
frame_count  out  8  frames completed since reset
collision  out  1  see Optional Feature

Behaviour:
- Reset: all outputs 0; all shadow and live sprites disabled, position 0, colour 0; frame_count 0; pipeline valids 0.
- Shadow write: wr_en=1 with wr_idx < NUM_SPRITES updates that shadow entry at the next edge; wr_idx >= NUM_SPRITES is discarded.
- Frame latch event: pixel_valid && x==H_ACTIVE-1 && y==V_ACTIVE-1 sampled at input. At the next edge, live <= shadow for all sprites and frame_count increments, wrapping 255->0. bg_mode is also latched into a live copy at this edge.
- Simultaneous wr_en and latch: the shadow takes the write. The live set takes the pre-write shadow value, so the write becomes visible one frame later.
- Stage 1 registers pixel_valid, x and y. Stage 2 computes the hit and colour and registers r/g/b, sprite_hit and out_valid. Latency is exactly 2 cycles. The pipeline runs every cycle with no stalls.
- Hit for sprite i: live enabled, sx <= x < sx+SPRITE_W, and sy <= y < sy+SPRITE_H. Compares are done at COORD_W+1 bits so sx+SPRITE_W never wraps. A sprite partly off-screen is clipped naturally.
- Priority: the lowest-indexed hitting sprite supplies the colour.
- Background, using low 8 bits of x/y:
  - mode 0: r=b=x^y, g=0.
  - mode 1: all 0.
  - mode 2: r=g=b=x[7:0].
  - mode 3: r=b=(x+frame_count)^y, g=0.
- When out_valid=0: r/g/b=0 and sprite_hit=0.
- Reset mid-frame: the pipeline flushes and outputs are 0 on the next cycle. Live sprites stay disabled until the first frame latch after reset.

Optional Feature:
Macro SPRITE_COLLIDE_EN.
- Defined: an internal sticky flag is set when two or more live enabled sprites hit the same valid pixel (evaluated in stage 2). At each frame latch, collision <= flag and the flag clears, unless a collision occurs in that same cycle, in which case the flag is set. collision therefore reports the previous frame and holds for a full frame.
- Undefined: no collision logic is built; collision is tied to 0.

Test Plan:
- Reset, then scan one frame with bg_mode=0 and no sprites -> at x=5,y=3 output r=b=6, g=0, sprite_hit=0, appearing exactly 2 cycles after input; out_valid tracks pixel_valid delayed 2.
- Write sprite0 enable, x=100, y=50, colour 0xFF0000; no frame latch yet -> pixel (120,60) still shows background. After the latch, in the next frame: (120,60) gives FF/00/00 with hit=1; (356,60), (99,60) and (120,114) give background.
- Sprite0 at (100,50) colour 0x00FF00 and sprite1 at (200,50) colour 0x0000FF, both enabled -> pixel (250,60) gives colour 00FF00 (lowest index wins). With SPRITE_COLLIDE_EN defined, collision=1 after the next latch and 0 one frame after the overlap is removed.
- Sprite at x=H_ACTIVE-10 -> hit for x in [1014,1023], no wrap into x=0..245.
- wr_en asserted on the latch cycle with x=300 -> the position is not live in the following frame, and is live one frame later.
- bg_mode=3 over 3 frames -> frame_count goes 0→1→2→3 and pixel (0,0) gives r=frame_count; at 255→0 the counter wraps with no glitch.
